// File: rtl/clk_dist_cfg_seq.sv
// clk_dist_cfg_seq: sequences distributor source/gate/drive changes so no output is live while its clock or drive switches.
module clk_dist_cfg_seq #(
    parameter int OUTPUTS     = 4,
    parameter int SETTLE_CYC  = 8,
    parameter int STAGGER_CYC = 2,
    parameter int SELW        = $clog2(OUTPUTS)
) (
    input  logic                   clk_out_o,
    input  logic                   rst_n,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [SELW-1:0]        req_sel_i,
    input  logic [OUTPUTS-1:0]     req_gate_i,
    input  logic [2*OUTPUTS-1:0]   req_drv_i,
    output logic [SELW-1:0]        sel_src_o,
    output logic [OUTPUTS-1:0]     gate_en_o,
    output logic [2*OUTPUTS-1:0]   drv_str_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o
);
    localparam int MAXC = SETTLE_CYC > STAGGER_CYC ? SETTLE_CYC : STAGGER_CYC;
    localparam int CW = $clog2(MAXC) + 1;
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] STAG_LD   = CW'(STAGGER_CYC - 1);

    typedef enum logic [1:0] {IDLE, SETTLE_OFF, SETTLE_ON, ENABLE} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [SELW-1:0]      lat_sel;
    logic [OUTPUTS-1:0]   lat_gate;
    logic [2*OUTPUTS-1:0] lat_drv;
    logic [OUTPUTS-1:0]   drv_chg, aff, pending, low;
    logic                 legal, sel_chg, full;

    always_comb begin
        drv_chg = '0;
        for (int i = 0; i < OUTPUTS; i++)
            drv_chg[i] = req_drv_i[2*i +: 2] != drv_str_o[2*i +: 2];
    end

    assign legal       = req_sel_i < SELW'(3);
    assign sel_chg     = req_sel_i != sel_src_o;
    assign aff         = sel_chg ? gate_en_o : gate_en_o & (~req_gate_i | drv_chg);
    assign full        = sel_chg || aff != '0;
    assign pending     = lat_gate & ~gate_en_o;
    // isolate the lowest pending bit so outputs come up one at a time
    assign low         = pending & (~pending + OUTPUTS'(1));
    assign req_ready_o = state == IDLE;
    assign busy_o      = state != IDLE;

    always_ff @(posedge clk_out_o) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_sel   <= '0;
            lat_gate  <= '0;
            lat_drv   <= '0;
            sel_src_o <= '0;
            gate_en_o <= '0;
            drv_str_o <= '0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid_i && !legal) begin
                        err_o <= 1'b1;
                    end else if (req_valid_i) begin
                        lat_sel  <= req_sel_i;
                        lat_gate <= req_gate_i;
                        lat_drv  <= req_drv_i;
                        if (full) begin
                            gate_en_o <= gate_en_o & ~aff;
                            state     <= SETTLE_OFF;
                            cnt       <= SETTLE_LD;
                        end else begin
                            drv_str_o <= req_drv_i;
                            state     <= ENABLE;
                            cnt       <= '0;
                        end
                    end
                end
                SETTLE_OFF: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        sel_src_o <= lat_sel;
                        drv_str_o <= lat_drv;
                        state     <= SETTLE_ON;
                        cnt       <= SETTLE_LD;
                    end
                end
                // the settle-on exit edge doubles as the first enable step
                default: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (pending != '0) begin
                        gate_en_o <= gate_en_o | low;
                        cnt       <= STAG_LD;
                        state     <= ENABLE;
                    end else begin
                        state  <= IDLE;
                        done_o <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_clk_dist_cfg_seq.sv
// tb_clk_dist_cfg_seq: directed table-driven checks of the clock distributor config sequencer.
module tb_clk_dist_cfg_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic [1:0] req_sel = '0;
    logic [3:0] req_gate = '0;
    logic [7:0] req_drv = '0;
    logic       req_ready, busy, done, err;
    logic [1:0] sel_src;
    logic [3:0] gate_en;
    logic [7:0] drv_str;

    int n_chk = 0;
    int n_pass = 0;

    clk_dist_cfg_seq #(.OUTPUTS(4), .SETTLE_CYC(8), .STAGGER_CYC(2)) dut (
        .clk_out_o(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_sel_i(req_sel), .req_gate_i(req_gate), .req_drv_i(req_drv),
        .sel_src_o(sel_src), .gate_en_o(gate_en), .drv_str_o(drv_str),
        .busy_o(busy), .done_o(done), .err_o(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         e;
        logic [1:0] sel;
        logic [3:0] gate;
        logic [7:0] drv;
        logic       dn;
        logic       bsy;
    } chk_t;

    chk_t tbl[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // {sel, gate, drv, done, err, busy, ready}
    function automatic logic [31:0] snap();
        return {14'b0, sel_src, gate_en, drv_str, done, err, busy, req_ready};
    endfunction

    task automatic add(input int e, input logic [1:0] s, input logic [3:0] g,
                       input logic [7:0] d, input logic dn, input logic b);
        chk_t c;
        c.e = e; c.sel = s; c.gate = g; c.drv = d; c.dn = dn; c.bsy = b;
        tbl.push_back(c);
    endtask

    task automatic run_tbl(input string nm);
        int now = 0;
        foreach (tbl[i]) begin
            while (now < tbl[i].e) begin
                tick();
                now++;
            end
            chk($sformatf("%s@E%0d", nm, tbl[i].e), snap(),
                {14'b0, tbl[i].sel, tbl[i].gate, tbl[i].drv, tbl[i].dn, 1'b0, tbl[i].bsy, ~tbl[i].bsy});
        end
        tbl.delete();
    endtask

    task automatic send(input logic [1:0] s, input logic [3:0] g, input logic [7:0] d);
        req_sel = s; req_gate = g; req_drv = d; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int bad;
        tick();
        tick();
        chk("reset_state", snap(), 32'h1);
        rst_n = 1'b1;
        tick();

        send(2'd1, 4'hF, 8'hFF);
        add(0, 0, 4'h0, 8'h00, 0, 1);  add(7, 0, 4'h0, 8'h00, 0, 1);
        add(8, 1, 4'h0, 8'hFF, 0, 1);  add(15, 1, 4'h0, 8'hFF, 0, 1);
        add(16, 1, 4'h1, 8'hFF, 0, 1); add(17, 1, 4'h1, 8'hFF, 0, 1);
        add(18, 1, 4'h3, 8'hFF, 0, 1); add(20, 1, 4'h7, 8'hFF, 0, 1);
        add(22, 1, 4'hF, 8'hFF, 0, 1); add(23, 1, 4'hF, 8'hFF, 0, 1);
        add(24, 1, 4'hF, 8'hFF, 1, 0); add(25, 1, 4'hF, 8'hFF, 0, 0);
        run_tbl("full1");

        send(2'd2, 4'hF, 8'hFF);
        add(0, 1, 4'h0, 8'hFF, 0, 1);  add(7, 1, 4'h0, 8'hFF, 0, 1);
        add(8, 2, 4'h0, 8'hFF, 0, 1);  add(16, 2, 4'h1, 8'hFF, 0, 1);
        add(18, 2, 4'h3, 8'hFF, 0, 1); add(20, 2, 4'h7, 8'hFF, 0, 1);
        add(22, 2, 4'hF, 8'hFF, 0, 1); add(24, 2, 4'hF, 8'hFF, 1, 0);
        run_tbl("full2");

        rst_n = 1'b0;
        tick();
        chk("reset_again", snap(), 32'h1);
        rst_n = 1'b1;
        send(2'd0, 4'h3, 8'h00);
        add(0, 0, 4'h0, 8'h00, 0, 1); add(1, 0, 4'h1, 8'h00, 0, 1);
        add(2, 0, 4'h1, 8'h00, 0, 1); add(3, 0, 4'h3, 8'h00, 0, 1);
        add(4, 0, 4'h3, 8'h00, 0, 1); add(5, 0, 4'h3, 8'h00, 1, 0);
        run_tbl("fast");

        send(2'd0, 4'h3, 8'h00);
        add(0, 0, 4'h3, 8'h00, 0, 1); add(1, 0, 4'h3, 8'h00, 1, 0);
        run_tbl("ident");

        send(2'd0, 4'h3, 8'h01);
        add(0, 0, 4'h2, 8'h00, 0, 1);  add(7, 0, 4'h2, 8'h00, 0, 1);
        add(8, 0, 4'h2, 8'h01, 0, 1);  add(16, 0, 4'h3, 8'h01, 0, 1);
        add(17, 0, 4'h3, 8'h01, 0, 1); add(18, 0, 4'h3, 8'h01, 1, 0);
        run_tbl("drvchg");

        send(2'd3, 4'hF, 8'hFF);
        chk("illegal_err", snap(), {14'b0, 2'd0, 4'h3, 8'h01, 1'b0, 1'b1, 1'b0, 1'b1});
        tick();
        chk("illegal_err_clr", snap(), {14'b0, 2'd0, 4'h3, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1});

        req_sel = 2'd1; req_gate = 4'h1; req_drv = 8'h00; req_valid = 1'b1;
        tick();
        req_sel = 2'd2;
        n = 0;
        bad = 0;
        while (!done && n < 100) begin
            if (req_ready) bad++;
            tick();
            n++;
        end
        chk("held_ready_low", 32'(bad), 32'd0);
        chk("held_done_cyc", 32'(n), 32'd18);
        chk("held_done_state", snap(), {14'b0, 2'd1, 4'h1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1});
        tick();
        req_valid = 1'b0;
        chk("held_accept", snap(), {14'b0, 2'd1, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0});
        n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        chk("held2_done_cyc", 32'(n), 32'd18);
        chk("held2_final", snap(), {14'b0, 2'd2, 4'h1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1});

        send(2'd0, 4'hF, 8'hFF);
        repeat (9) tick();
        chk("mid_E9", snap(), {14'b0, 2'd0, 4'h0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0});
        rst_n = 1'b0;
        tick();
        chk("mid_reset", snap(), 32'h1);
        rst_n = 1'b1;
        repeat (3) tick();
        chk("mid_discard", snap(), 32'h1);
        send(2'd1, 4'h1, 8'h00);
        add(0, 0, 4'h0, 8'h00, 0, 1);  add(8, 1, 4'h0, 8'h00, 0, 1);
        add(16, 1, 4'h1, 8'h00, 0, 1); add(18, 1, 4'h1, 8'h00, 1, 0);
        run_tbl("after_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
